// File: rtl/ka193_pkg.sv
// Shared widths and FSM state encoding for the 193-bit Karatsuba
// sequencer around an external 97x97 carry-less sub-multiplier.
package ka193_pkg;

  localparam int unsigned HalfW = 97;
  localparam int unsigned FullW = 2 * HalfW - 1;
  localparam int unsigned ProdW = 2 * HalfW - 1;
  localparam int unsigned ResW  = 2 * FullW - 1;

  typedef enum logic [2:0] {
    StIdle,
    StM0,
    StM1,
    StM2,
    StFin
  } state_e;

endpackage

// File: rtl/ka193_combine.sv
// Karatsuba recombination: P0 ^ ((P0^P1^P2) << HW) ^ (P1 << 2*HW).
module ka193_combine
  import ka193_pkg::*;
#(
  parameter int unsigned HW = HalfW,
  parameter int unsigned W  = FullW
) (
  input  logic [2*HW-2:0] p0,
  input  logic [2*HW-2:0] p1,
  input  logic [2*HW-2:0] p2,
  output logic [2*W-2:0]  result
);

  localparam int unsigned RW = 2 * W - 1;

  logic [RW-1:0] p0_x;
  logic [RW-1:0] mid_x;
  logic [RW-1:0] p1_x;

  assign p0_x  = RW'(p0);
  assign mid_x = RW'(p0 ^ p1 ^ p2);
  assign p1_x  = RW'(p1);

  // P1 has degree <= 2*(HW-2), so the top shift never loses set bits.
  assign result = p0_x ^ (mid_x << HW) ^ (p1_x << (2 * HW));

endmodule

// File: rtl/ka193_seq_ctrl.sv
// Sequences three sub-multiplications (a0*b0, a1*b1, (a0^a1)*(b0^b1)) over a
// shared HW x HW port, then recombines them into the full GF(2) product.
module ka193_seq_ctrl
  import ka193_pkg::*;
#(
  parameter int unsigned HW = HalfW,
  parameter int unsigned W  = FullW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W-1:0]      a,
  input  logic [W-1:0]      b,
  output logic              busy,
  output logic              done,
  output logic [2*W-2:0]    result,
  output logic              mul_req,
  output logic [HW-1:0]     mul_a,
  output logic [HW-1:0]     mul_b,
  input  logic              mul_ack,
  input  logic [2*HW-2:0]   mul_p
);

  localparam int unsigned PW = 2 * HW - 1;
  localparam int unsigned RW = 2 * W - 1;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, b_q;
  logic [PW-1:0] p0_q, p1_q, p2_q;
  logic [RW-1:0] result_q, comb_result;
  logic          done_q;

  logic [HW-1:0] a0, a1, b0, b1;
  logic          accept;
  logic          ack;

  assign a0 = a_q[HW-1:0];
  assign a1 = {1'b0, a_q[W-1:HW]};
  assign b0 = b_q[HW-1:0];
  assign b1 = {1'b0, b_q[W-1:HW]};

  assign accept = (state_q == StIdle) && start;
  // Acks outside a request window are dropped here.
  assign ack    = mul_req && mul_ack;

  always_comb begin
    state_d = state_q;
    mul_req = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    unique case (state_q)
      StIdle: if (start) state_d = StM0;
      StM0: begin
        mul_req = 1'b1;
        mul_a   = a0;
        mul_b   = b0;
        if (mul_ack) state_d = StM1;
      end
      StM1: begin
        mul_req = 1'b1;
        mul_a   = a1;
        mul_b   = b1;
        if (mul_ack) state_d = StM2;
      end
      StM2: begin
        mul_req = 1'b1;
        mul_a   = a0 ^ a1;
        mul_b   = b0 ^ b1;
        if (mul_ack) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      p0_q     <= '0;
      p1_q     <= '0;
      p2_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StFin);
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      if (ack && state_q == StM0) p0_q <= mul_p;
      if (ack && state_q == StM1) p1_q <= mul_p;
      if (ack && state_q == StM2) p2_q <= mul_p;
      if (state_q == StFin) result_q <= comb_result;
    end
  end

  ka193_combine #(
    .HW (HW),
    .W  (W)
  ) u_combine (
    .p0     (p0_q),
    .p1     (p1_q),
    .p2     (p2_q),
    .result (comb_result)
  );

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_ka193_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected products, a monitor checks them
// on done, and a behavioural sub-multiplier answers requests with random delay.
module tb_ka193_seq_ctrl;

  localparam int unsigned HW = 97;
  localparam int unsigned W  = 193;
  localparam int unsigned PW = 2 * HW - 1;
  localparam int unsigned RW = 2 * W - 1;

  typedef struct {
    logic [RW-1:0] res;
    longint        due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [RW-1:0] result;
  logic          mul_req;
  logic [HW-1:0] mul_a, mul_b;
  logic          mul_ack = 1'b0;
  logic [PW-1:0] mul_p = '0;

  exp_t   exp_q[$];
  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;
  int     ack_max = 0;
  bit     spur = 1'b0;
  int     req_cnt = 0;

  ka193_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
    .mul_p   (mul_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] clmul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) if (y[i]) r = r ^ (RW'(x) << i);
    return r;
  endfunction

  function automatic logic [PW-1:0] clmul_h(input logic [HW-1:0] x, input logic [HW-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < HW; i++) if (y[i]) r = r ^ (PW'(x) << i);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [223:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic chk_vec(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sub-multiplier model; also checks operand stability across a request.
  logic [HW-1:0] hold_a, hold_b;
  bit            pending = 1'b0;
  int            dly = 0;
  always @(negedge clk) begin
    mul_ack = 1'b0;
    if (spur) begin
      mul_ack = 1'b1;
      mul_p   = PW'(rnd_w());
      spur    = 1'b0;
    end else if (mul_req) begin
      req_cnt++;
      if (!pending) begin
        pending = 1'b1;
        dly     = int'($urandom_range(ack_max, 0));
        hold_a  = mul_a;
        hold_b  = mul_b;
      end else begin
        chk_vec("mul_a_stable", RW'(mul_a), RW'(hold_a));
        chk_vec("mul_b_stable", RW'(mul_b), RW'(hold_b));
      end
      if (dly == 0) begin
        mul_ack = 1'b1;
        mul_p   = clmul_h(mul_a, mul_b);
        pending = 1'b0;
      end else begin
        dly--;
      end
    end else begin
      pending = 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        chk_vec("result", result, e.res);
        if (e.due >= 0) chk_int("done_latency", cyc, e.due);
      end
    end
  end

  // Call on a negedge; returns on the negedge after start was accepted.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [RW-1:0] texp, input bit lat);
    int guard = 0;
    exp_t e;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy) chk_int("issue_timeout", 1, 0);
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    e.res = texp;
    e.due = lat ? cyc + 5 : -1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk_int("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic spur_ack();
    @(posedge clk);
    #1 spur = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  ta, tb_v;
    logic [RW-1:0] te, first_res;
    exp_t          e;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk_int("rst_busy", longint'(busy), 0);
    chk_int("rst_done", longint'(done), 0);
    chk_int("rst_mul_req", longint'(mul_req), 0);
    chk_vec("rst_mul_a", RW'(mul_a), '0);
    chk_vec("rst_mul_b", RW'(mul_b), '0);
    chk_vec("rst_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1 * 1 with zero-wait acks
    ack_max = 0;
    req_cnt = 0;
    issue(W'(1), W'(1), RW'(1), 1'b1);
    drain();
    chk_int("mul_req_cycles", req_cnt, 3);

    // Top-bit and cross-half boundaries
    ta = '0; ta[192] = 1'b1;
    te = '0; te[384] = 1'b1;
    issue(ta, ta, te, 1'b1);
    ta = '0; ta[97] = 1'b1;
    tb_v = W'(3);
    te = '0; te[97] = 1'b1; te[98] = 1'b1;
    issue(ta, tb_v, te, 1'b1);
    drain();

    // start during M1 ignored; ack in IDLE ignored
    ta = W'(193'h1_2345_6789);
    tb_v = W'(193'h5);
    first_res = clmul(ta, tb_v);
    issue(ta, tb_v, first_res, 1'b1);
    @(negedge clk);
    a = rnd_w();
    b = rnd_w();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    spur_ack();
    repeat (3) @(negedge clk);
    chk_vec("result_hold", result, first_res);
    chk_int("idle_busy", longint'(busy), 0);
    chk_int("idle_mul_req", longint'(mul_req), 0);

    // start held high: one done every 5 cycles
    ta = rnd_w();
    tb_v = rnd_w();
    a = ta;
    b = tb_v;
    start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      e.res = clmul(ta, tb_v);
      e.due = cyc + 5 * k;
      exp_q.push_back(e);
    end
    repeat (20) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during M2, stray ack, then all-ones
    issue(rnd_w(), rnd_w(), '0, 1'b0);
    repeat (2) @(negedge clk);
    chk_int("m2_mul_req", longint'(mul_req), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_int("mid_rst_busy", longint'(busy), 0);
    chk_int("mid_rst_mul_req", longint'(mul_req), 0);
    chk_int("mid_rst_done", longint'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    spur_ack();
    repeat (6) @(negedge clk);
    chk_vec("post_rst_result", result, '0);
    ta = '1;
    issue(ta, ta, clmul(ta, ta), 1'b1);
    drain();

    // Random operands, random ack delay 0..7
    ack_max = 7;
    for (int it = 0; it < 1000; it++) begin
      ta = rnd_w();
      tb_v = rnd_w();
      issue(ta, tb_v, clmul(ta, tb_v), 1'b0);
    end
    drain();
    chk_int("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
